// File: rtl/rv32i_pkg.sv
// Shared RV32I_X pipeline definitions: opcodes, MEM-stage FSM states and
// opcode classification helpers used by decode, exe_alu and mem_lsu.
package rv32i_pkg;

  localparam logic [31:0] OP_NOP   = 32'd0;
  localparam logic [31:0] OP_ADD   = 32'd1;
  localparam logic [31:0] OP_SUB   = 32'd2;
  localparam logic [31:0] OP_AND   = 32'd3;
  localparam logic [31:0] OP_OR    = 32'd4;
  localparam logic [31:0] OP_XOR   = 32'd5;
  localparam logic [31:0] OP_SLL   = 32'd6;
  localparam logic [31:0] OP_SRL   = 32'd7;
  localparam logic [31:0] OP_SRA   = 32'd8;
  localparam logic [31:0] OP_SLT   = 32'd9;
  localparam logic [31:0] OP_SLTU  = 32'd10;
  localparam logic [31:0] OP_LUI   = 32'd11;
  localparam logic [31:0] OP_AUIPC = 32'd12;

  localparam logic [31:0] OP_LB    = 32'd16;
  localparam logic [31:0] OP_LH    = 32'd17;
  localparam logic [31:0] OP_LW    = 32'd18;
  localparam logic [31:0] OP_LBU   = 32'd19;
  localparam logic [31:0] OP_LHU   = 32'd20;
  localparam logic [31:0] OP_SB    = 32'd21;
  localparam logic [31:0] OP_SH    = 32'd22;
  localparam logic [31:0] OP_SW    = 32'd23;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_e;

  function automatic logic is_load(input logic [31:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
           (op == OP_LBU) || (op == OP_LHU);
  endfunction

  function automatic logic is_store(input logic [31:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic is_mem_op(input logic [31:0] op);
    return is_load(op) || is_store(op);
  endfunction

  // Word ops need addr[1:0]==0, halfword ops need addr[0]==0.
  function automatic logic is_misaligned(input logic [31:0] op, input logic [1:0] lo);
    logic mis;
    mis = 1'b0;
    if ((op == OP_LW) || (op == OP_SW))
      mis = (lo != 2'b00);
    else if ((op == OP_LH) || (op == OP_LHU) || (op == OP_SH))
      mis = lo[0];
    return mis;
  endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// Data-memory req/gnt/rvalid bus between the MEM stage and data memory.
interface mem_lsu_if #(
  parameter int unsigned XLEN = 32
);
  logic            req;
  logic            we;
  logic [XLEN-1:0] addr;
  logic [3:0]      be;
  logic [XLEN-1:0] wdata;
  logic            gnt;
  logic            rvalid;
  logic [XLEN-1:0] rdata;

  modport master (
    output req, we, addr, be, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/mem_lsu_align.sv
// Combinational byte-lane logic: store byte enables / lane replication and
// load lane extraction with sign or zero extension.
module mem_lsu_align
  import rv32i_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned OP_W = 32
) (
  input  logic [OP_W-1:0] op,
  input  logic [1:0]      lo,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] rdata,
  output logic [3:0]      be,
  output logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_data
);

  logic [15:0] lane;

  always_comb begin
    be        = '0;
    wdata     = '0;
    load_data = '0;
    lane      = 16'(rdata >> {lo, 3'b000});
    case (op)
      OP_SB: begin
        be    = 4'b0001 << lo;
        wdata = {4{store_data[7:0]}};
      end
      OP_SH: begin
        be    = 4'b0011 << lo;
        wdata = {2{store_data[15:0]}};
      end
      OP_SW: begin
        be    = '1;
        wdata = store_data;
      end
      OP_LB: begin
        be        = 4'b0001 << lo;
        load_data = {{(XLEN-8){lane[7]}}, lane[7:0]};
      end
      OP_LBU: begin
        be        = 4'b0001 << lo;
        load_data = {{(XLEN-8){1'b0}}, lane[7:0]};
      end
      OP_LH: begin
        be        = 4'b0011 << lo;
        load_data = {{(XLEN-16){lane[15]}}, lane};
      end
      OP_LHU: begin
        be        = 4'b0011 << lo;
        load_data = {{(XLEN-16){1'b0}}, lane};
      end
      OP_LW: begin
        be        = '1;
        load_data = rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM stage of the RV32I_X pipeline: single-register pass-through for ALU
// results and a req/gnt/rvalid load/store unit that stalls upstream while busy.
module mem_lsu
  import rv32i_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned OP_W  = 32,
  parameter int unsigned RD_W  = 11,
  parameter int unsigned TMO_W = 8
) (
  input  logic            clk,
  input  logic            rstl,
  input  logic            valid_exe_2_mem_i,
  input  logic [OP_W-1:0] opcode_exe_2_mem_i,
  input  logic [RD_W-1:0] rd_exe_2_mem_i,
  input  logic [XLEN-1:0] rd_data_exe_2_mem_i,
  input  logic [XLEN-1:0] mem_address_i,
  input  logic [XLEN-1:0] mem_data_i,
  input  logic            flush_i,
  output logic            stall_mem_o,
  mem_lsu_if.master       dmem,
  output logic            valid_mem_2_wb_o,
  output logic [RD_W-1:0] rd_mem_2_wb_o,
  output logic [XLEN-1:0] rd_data_mem_2_wb_o,
  output logic            misalign_o,
  output logic            buserr_o
);

  // Last RESP cycle index before timeout: the 2**TMO_W-1'th cycle has count 2**TMO_W-2.
  localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

  lsu_state_e      state;
  logic [OP_W-1:0] op_q;
  logic [RD_W-1:0] rd_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] data_q;
  logic            discard_q;
  logic [TMO_W-1:0] tmo_cnt;

  logic            accept;
  logic            in_mem;
  logic            in_mis;
  logic            store_done;
  logic            rsp_hit;
  logic            tmo_hit;
  logic [3:0]      al_be;
  logic [XLEN-1:0] al_wdata;
  logic [XLEN-1:0] al_load;

  mem_lsu_align #(
    .XLEN (XLEN),
    .OP_W (OP_W)
  ) u_align (
    .op         (op_q),
    .lo         (addr_q[1:0]),
    .store_data (data_q),
    .rdata      (dmem.rdata),
    .be         (al_be),
    .wdata      (al_wdata),
    .load_data  (al_load)
  );

  always_comb begin
    accept     = (state == ST_IDLE) && valid_exe_2_mem_i && !flush_i && !rstl;
    in_mem     = is_mem_op(opcode_exe_2_mem_i);
    in_mis     = is_misaligned(opcode_exe_2_mem_i, mem_address_i[1:0]);
    store_done = (state == ST_REQ) && dmem.gnt && is_store(op_q);
    rsp_hit    = (state == ST_RESP) && dmem.rvalid;
    tmo_hit    = (state == ST_RESP) && !dmem.rvalid && (tmo_cnt == TMO_LAST);
    // Stall rises in the accept cycle and falls in the completing cycle so upstream
    // advances on the same edge the FSM returns to IDLE.
    stall_mem_o = !rstl && ((accept && in_mem && !in_mis) ||
                            ((state != ST_IDLE) && !(store_done || rsp_hit || tmo_hit)));
    dmem.req   = (state == ST_REQ);
    dmem.we    = (state == ST_REQ) && is_store(op_q);
    dmem.addr  = (state == ST_REQ) ? {addr_q[XLEN-1:2], 2'b00} : '0;
    dmem.be    = (state == ST_REQ) ? al_be : '0;
    dmem.wdata = (state == ST_REQ) ? al_wdata : '0;
  end

  always_ff @(posedge clk) begin
    if (rstl) begin
      state              <= ST_IDLE;
      op_q               <= '0;
      rd_q               <= '0;
      addr_q             <= '0;
      data_q             <= '0;
      discard_q          <= 1'b0;
      tmo_cnt            <= '0;
      valid_mem_2_wb_o   <= 1'b0;
      rd_mem_2_wb_o      <= '0;
      rd_data_mem_2_wb_o <= '0;
      misalign_o         <= 1'b0;
      buserr_o           <= 1'b0;
    end else begin
      valid_mem_2_wb_o <= 1'b0;
      misalign_o       <= 1'b0;
      buserr_o         <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (!in_mem) begin
              if (rd_exe_2_mem_i != '0) begin
                valid_mem_2_wb_o   <= 1'b1;
                rd_mem_2_wb_o      <= rd_exe_2_mem_i;
                rd_data_mem_2_wb_o <= rd_data_exe_2_mem_i;
              end
            end else if (in_mis) begin
              misalign_o <= 1'b1;
            end else begin
              op_q      <= opcode_exe_2_mem_i;
              rd_q      <= rd_exe_2_mem_i;
              addr_q    <= mem_address_i;
              data_q    <= mem_data_i;
              discard_q <= 1'b0;
              tmo_cnt   <= '0;
              state     <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          // A grant wins over a same-cycle flush: the bus already took the access.
          if (dmem.gnt) begin
            if (is_store(op_q)) begin
              state <= ST_IDLE;
            end else begin
              state     <= ST_RESP;
              tmo_cnt   <= '0;
              discard_q <= flush_i;
            end
          end else if (flush_i) begin
            state <= ST_IDLE;
          end
        end
        ST_RESP: begin
          if (dmem.rvalid) begin
            state <= ST_IDLE;
            if (!(discard_q || flush_i) && (rd_q != '0)) begin
              valid_mem_2_wb_o   <= 1'b1;
              rd_mem_2_wb_o      <= rd_q;
              rd_data_mem_2_wb_o <= al_load;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            state    <= ST_IDLE;
            buserr_o <= !(discard_q || flush_i);
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
            if (flush_i) discard_q <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
